// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
// Holds the FSM state encoding and the word/byte geometry of the port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 synchronous RAM; read data registered, 1-cycle latency.
// No reset and no backpressure: the caller strobes en only when it commits an access.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [IDX_W-1:0]          idx,
  input  logic [WORD_BYTES*8-1:0]   wdata,
  output logic [WORD_BYTES*8-1:0]   rdata
);

  logic [WORD_BYTES*8-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response strobe LATENCY cycles after accept.
// req_ready is low from accept through the response cycle; stall freezes the CPU meanwhile.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int          IDX_W    = clog2(DEPTH);
  localparam int          DW       = WORD_BYTES * 8;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 2);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        commit;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic        c_write;
  logic [31:0] c_addr, c_wdata;
  logic        c_err;
  logic        rd_ok;
  logic [DW-1:0] ram_rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With a single-cycle latency the commit edge is the accept edge, so use the live request.
  assign c_write = (state == IDLE) ? req_write : lat_write;
  assign c_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign c_err   = (c_addr[ADDR_LSB-1:0] != '0) || ((c_addr >> (IDX_W + ADDR_LSB)) != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      resp_err  <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        resp_err <= c_err;
        rd_ok    <= ~c_err & ~c_write;
      end
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (commit & ~c_err & ~rst),
    .we    (c_write),
    .idx   (c_addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  // RAM output is only meaningful after a good load; everything else reads as zero.
  assign resp_rdata = rd_ok ? ram_rdata : 32'd0;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign stall      = req_valid & ~resp_valid;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port.
- Accepts one load/store request at a time from the MEM stage over a valid/ready request channel. Performs the access after a configurable latency, then returns a one-cycle response.
- Drives a stall signal that the CPU uses to freeze the pipeline while an access is outstanding.
- Replaces the zero-latency data memory for multi-cycle memory experiments.

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two, 4..4096.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  CPU presents a request (MemRead or MemWrite active in MEM).
- req_write  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rt value).
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  response strobe, exactly one cycle per accepted request.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range; valid with resp_valid.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; equals req_valid & ~resp_valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; latency counter=0.
  - Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1 at a rising edge, latch req_write, req_addr and req_wdata.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - When cnt==0, go to RESP.
  - Request inputs are ignored; the latched copy is authoritative.
- Transition into RESP (the commit edge):
  - Access performed on latched values; word index = addr[log2(DEPTH)+1:2].
  - Store: the word is written, resp_rdata=0.
  - Load: resp_rdata=mem[index].
  - Error when addr[1:0]!=0 or addr[31:log2(DEPTH)+2]!=0: no write, resp_rdata=0, resp_err=1.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; then IDLE.
  - resp_rdata and resp_err hold until the next commit edge. resp_err clears on the next non-error commit.
- Latency and throughput:
  - resp_valid rises exactly LATENCY cycles after the acceptance edge.
  - Back-to-back requests are accepted every LATENCY+1 cycles. A request held high across RESP is re-accepted in the following IDLE cycle. The CPU is responsible for deasserting req_valid once the pipeline advances.
- stall is combinational. It is 0 in the RESP cycle so the pipeline advances with the response, and 0 when req_valid=0.
- Read-after-write to the same address returns the new data; accesses are strictly serialized.
- Reset during WAIT aborts the request. An uncommitted store does not modify memory. A store committed before reset persists.
- req_valid dropping during WAIT does not cancel the access; the response is still produced.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - constants WORD_BYTES=4 and ADDR_LSB=2;
  - the function clog2 used for index width.
- One sub-module, dmem_ram:
  - single-port synchronous RAM, DEPTH x 32;
  - write enable, registered read data, no reset;
  - instantiated once and driven only on the commit edge.

Test Plan:
- Reset then idle, LATENCY=2: all outputs at reset values; req_ready=1; stall=0 with req_valid=0.
- Store 0xDEADBEEF to 0x10, then load 0x10, LATENCY=2:
  - store response at acceptance+2 with rdata=0 and err=0;
  - load response at acceptance+2 with rdata=0xDEADBEEF;
  - stall high for exactly 2 cycles per access.
- LATENCY=1 and LATENCY=15 sweep: resp_valid rises exactly 1 and 15 cycles after acceptance; req_ready=0 throughout WAIT and RESP.
- Misaligned load at 0x13 and store to 0x400 with DEPTH=256:
  - both return resp_err=1 and rdata=0;
  - a subsequent load of word 0 is unchanged.
- Async reset asserted mid-WAIT on a store of 0x12345678 to 0x20: outputs reset immediately; a later load of 0x20 returns the prior value.
- req_valid held high continuously for 3 loads: exactly 3 accept/response pairs, spaced LATENCY+1 cycles apart.
